// File: rtl/frame_painter.sv
// Full-frame raster painter: sweeps H_RES x V_RES pixels once per start and writes fill/ROM colours.
// Optional build macro FRAME_BORDER_EN forces BORDER_COLOUR on the outermost rows and columns.
module frame_painter #(
    parameter int             H_RES         = 160,
    parameter int             V_RES         = 120,
    parameter int             XW            = 8,
    parameter int             YW            = 7,
    parameter int             AW            = 15,
    parameter int             CW            = 3,
    parameter logic [CW-1:0]  FILL_COLOUR   = '0,
    parameter logic [CW-1:0]  KEY_COLOUR    = 3'b100,
    parameter logic [CW-1:0]  BORDER_COLOUR = 3'b111
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [1:0]    mode,
    output logic [AW-1:0] rom_addr,
    input  logic [CW-1:0] rom_a_q,
    input  logic [CW-1:0] rom_b_q,
    output logic          busy,
    output logic          done,
    output logic          wren,
    output logic [XW-1:0] x,
    output logic [YW-1:0] y,
    output logic [CW-1:0] colour
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_PAINT = 2'd1;
    localparam logic [1:0] S_FLUSH = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam logic [XW-1:0] X_LAST = XW'(H_RES - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(V_RES - 1);

    logic [1:0]    state;
    logic [1:0]    mode_lat;
    logic [XW-1:0] x_cnt;
    logic [YW-1:0] y_cnt;
    logic [AW-1:0] addr_cnt;

    logic          vld_p1;
    logic [XW-1:0] x_p1;
    logic [YW-1:0] y_p1;
    logic [CW-1:0] pix_colour;

    function automatic logic [CW-1:0] select_colour(input logic [1:0]    m,
                                                    input logic [CW-1:0] qa,
                                                    input logic [CW-1:0] qb);
        logic [CW-1:0] c;
        case (m)
            2'd0:    c = FILL_COLOUR;
            2'd1:    c = qa;
            2'd2:    c = qb;
            default: c = (qb == KEY_COLOUR) ? FILL_COLOUR : qb;
        endcase
        return c;
    endfunction

    // Stage 0: raster counters issue one pixel address per PAINT cycle
    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= S_IDLE;
            mode_lat <= 2'd0;
            x_cnt    <= '0;
            y_cnt    <= '0;
            addr_cnt <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state    <= S_PAINT;
                        mode_lat <= mode;
                        x_cnt    <= '0;
                        y_cnt    <= '0;
                        addr_cnt <= '0;
                    end
                end
                S_PAINT: begin
                    if (x_cnt == X_LAST) begin
                        if (y_cnt == Y_LAST) begin
                            // Counters park on the last pixel; the address never wraps
                            state <= S_FLUSH;
                        end else begin
                            x_cnt    <= '0;
                            y_cnt    <= y_cnt + YW'(1);
                            addr_cnt <= addr_cnt + AW'(1);
                        end
                    end else begin
                        x_cnt    <= x_cnt + XW'(1);
                        addr_cnt <= addr_cnt + AW'(1);
                    end
                end
                S_FLUSH: state <= S_DONE;
                default: state <= S_IDLE;
            endcase
        end
    end

    // Stage 1: coordinates delayed to line up with the registered ROM data
    always_ff @(posedge clk) begin
        if (!rst) begin
            vld_p1 <= 1'b0;
            x_p1   <= '0;
            y_p1   <= '0;
        end else begin
            vld_p1 <= (state == S_PAINT);
            x_p1   <= x_cnt;
            y_p1   <= y_cnt;
        end
    end

    always_comb begin
        pix_colour = select_colour(mode_lat, rom_a_q, rom_b_q);
`ifdef FRAME_BORDER_EN
        if (x_p1 == '0 || x_p1 == X_LAST || y_p1 == '0 || y_p1 == Y_LAST) begin
            pix_colour = BORDER_COLOUR;
        end
`endif
    end

`ifndef FRAME_BORDER_EN
    logic unused_border;
    assign unused_border = ^BORDER_COLOUR;
`endif

    assign rom_addr = addr_cnt;
    assign busy     = (state != S_IDLE);
    assign done     = (state == S_DONE);
    assign wren     = vld_p1;
    assign x        = x_p1;
    assign y        = y_p1;
    assign colour   = vld_p1 ? pix_colour : '0;

endmodule

// File: tb/tb_frame_painter.sv
// Directed bench for frame_painter at 160x120: fill, ROM A, keyed ROM B, handshake, mid-frame reset, border.
module tb_frame_painter;

    localparam int H = 160;
    localparam int V = 120;
    localparam int N = H * V;

    logic        clk   = 1'b0;
    logic        rst   = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  mode  = 2'd0;
    logic [14:0] rom_addr;
    logic [2:0]  rom_a_q;
    logic [2:0]  rom_b_q;
    logic        busy;
    logic        done;
    logic        wren;
    logic [7:0]  x;
    logic [6:0]  y;
    logic [2:0]  colour;

    int checks   = 0;
    int failures = 0;
    int a_pat    = 0;

    int nwr, first, gaps, pos_err, col_err, done_at, done_cnt;
    logic busy_after;
    int       cap_x   [N];
    int       cap_y   [N];
    logic [2:0] cap_col [N];

    frame_painter dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .mode     (mode),
        .rom_addr (rom_addr),
        .rom_a_q  (rom_a_q),
        .rom_b_q  (rom_b_q),
        .busy     (busy),
        .done     (done),
        .wren     (wren),
        .x        (x),
        .y        (y),
        .colour   (colour)
    );

    always #5 clk = ~clk;

    function automatic logic [2:0] rom_a(input int a);
        return (a_pat == 0) ? 3'(a % 8) : 3'b010;
    endfunction

    function automatic logic [2:0] rom_b(input int a);
        return (a % 2 == 1) ? 3'b011 : 3'b100;
    endfunction

    always_ff @(posedge clk) begin
        rom_a_q <= rom_a(int'(rom_addr));
        rom_b_q <= rom_b(int'(rom_addr));
    end

    function automatic logic [2:0] exp_colour(input logic [1:0] m, input int px, input int py);
        int a;
        logic [2:0] b;
        a = py * H + px;
        b = rom_b(a);
`ifdef FRAME_BORDER_EN
        if (px == 0 || px == H - 1 || py == 0 || py == V - 1) return 3'b111;
`endif
        case (m)
            2'd0:    return 3'b000;
            2'd1:    return rom_a(a);
            2'd2:    return b;
            default: return (b == 3'b100) ? 3'b000 : b;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Pulses start for one cycle from IDLE and records the whole frame until one cycle after done.
    task automatic run_frame(input logic [1:0] m, input int repulse_at);
        logic prev;
        mode = m; start = 1'b1;
        nwr = 0; first = -1; gaps = 0; pos_err = 0; col_err = 0;
        done_at = -1; done_cnt = 0; busy_after = 1'b1; prev = 1'b0;
        for (int c = 1; c <= 25000; c++) begin
            @(negedge clk);
            if (c == 1) start = 1'b0;
            if (wren) begin
                if (first < 0) first = c;
                else if (!prev) gaps++;
                if (nwr < N) begin
                    cap_x[nwr]   = int'(x);
                    cap_y[nwr]   = int'(y);
                    cap_col[nwr] = colour;
                    if (int'(x) != nwr % H || int'(y) != nwr / H) pos_err++;
                    if (colour !== exp_colour(m, nwr % H, nwr / H)) col_err++;
                end
                nwr++;
            end
            prev = wren;
            if (done) begin
                done_cnt++;
                if (done_at < 0) done_at = c;
            end
            if (repulse_at >= 0) begin
                if (nwr == repulse_at) begin
                    start = 1'b1;
                    mode  = 2'd1;
                end else if (nwr == repulse_at + 1) begin
                    start = 1'b0;
                end
            end
            if (done_at >= 0 && c == done_at + 1) begin
                busy_after = busy;
                break;
            end
        end
        start = 1'b0;
    endtask

    task automatic frame_checks(input string tag);
        check({tag, "_first_wren"}, first, 2);
        check({tag, "_wren_count"}, nwr, N);
        check({tag, "_wren_gaps"}, gaps, 0);
        check({tag, "_xy_errors"}, pos_err, 0);
        check({tag, "_colour_errors"}, col_err, 0);
        check({tag, "_done_cycle"}, done_at, first + N);
        check({tag, "_done_width"}, done_cnt, 1);
        check({tag, "_busy_after"}, busy_after, 0);
    endtask

    initial begin
        int cnt;
        int seen;

        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_wren", wren, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_x", x, 0);
        check("rst_y", y, 0);
        check("rst_colour", colour, 0);
        check("rst_rom_addr", rom_addr, 0);
        rst = 1'b1;
        @(negedge clk);

        a_pat = 0;
        run_frame(2'd0, -1);
        frame_checks("fill");
        check("fill_first_x", cap_x[0], 0);
        check("fill_first_y", cap_y[0], 0);
        check("fill_last_x", cap_x[N-1], 159);
        check("fill_last_y", cap_y[N-1], 119);

        run_frame(2'd1, -1);
        frame_checks("roma");
        check("roma_159_0_x", cap_x[159], 159);
        check("roma_159_0_y", cap_y[159], 0);
        check("roma_159_0_col", cap_col[159], 7);
        check("roma_0_1_x", cap_x[160], 0);
        check("roma_0_1_y", cap_y[160], 1);
`ifdef FRAME_BORDER_EN
        check("roma_0_1_col", cap_col[160], 7);
`else
        check("roma_0_1_col", cap_col[160], 0);
`endif
        check("roma_1_1_x", cap_x[161], 1);
        check("roma_1_1_col", cap_col[161], 1);

        run_frame(2'd3, -1);
        frame_checks("keyed");
        check("keyed_even_col", cap_col[330], 0);
        check("keyed_odd_col", cap_col[331], 3);

        run_frame(2'd0, 500);
        frame_checks("repulse");

        // start held high: second frame begins right after one IDLE cycle
        mode = 2'd0; start = 1'b1;
        seen = 0;
        for (int c = 0; c < 25000; c++) begin
            @(negedge clk);
            if (done) begin seen = 1; break; end
        end
        check("hold_first_done", seen, 1);
        cnt = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            cnt++;
            if (wren) break;
        end
        check("hold_restart_gap", cnt, 3);
        start = 1'b0;
        nwr = 1; seen = 0;
        for (int c = 0; c < 25000; c++) begin
            @(negedge clk);
            if (wren) nwr++;
            if (done) begin seen = 1; break; end
        end
        check("hold_second_done", seen, 1);
        check("hold_second_count", nwr, N);
        @(negedge clk);

        // reset while pixel 1000 is being written
        mode = 2'd2; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cnt = 0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            if (wren) cnt++;
            if (cnt == 1001) break;
        end
        check("midrst_reached", cnt, 1001);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        check("midrst_wren", wren, 0);
        check("midrst_busy", busy, 0);
        check("midrst_done", done, 0);
        check("midrst_rom_addr", rom_addr, 0);
        cnt = 0;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (wren || done) cnt++;
        end
        check("midrst_quiet", cnt, 0);
        run_frame(2'd2, -1);
        frame_checks("after_rst");

        a_pat = 1;
        run_frame(2'd1, -1);
        frame_checks("border");
`ifdef FRAME_BORDER_EN
        check("border_0_5", cap_col[5*H+0], 7);
        check("border_159_7", cap_col[7*H+159], 7);
        check("border_3_0", cap_col[3], 7);
        check("border_3_119", cap_col[119*H+3], 7);
`else
        check("border_0_5", cap_col[5*H+0], 2);
        check("border_159_7", cap_col[7*H+159], 2);
        check("border_3_0", cap_col[3], 2);
        check("border_3_119", cap_col[119*H+3], 2);
`endif
        check("border_1_1", cap_col[H+1], 2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/frame_painter.md
Name: frame_painter

Overview:
- Parametrised full-frame painter for the VGA framebuffer path; successor to the fixed 160x120 screen-fill logic.
- On a start pulse it sweeps every pixel once in raster order and writes a colour from one of four sources: solid fill, image ROM A, image ROM B, or ROM B with key colour masked.
- Has a start/busy/done handshake and compensates for one-cycle registered ROM latency, so x/y/colour/wren are aligned.
- x/y come from raster counters, not divide/modulo.

Parameters:
- H_RES, 160, pixels per line
- V_RES, 120, lines per frame
- XW, 8, x output width; must satisfy 2^XW >= H_RES
- YW, 7, y output width; must satisfy 2^YW >= V_RES
- AW, 15, ROM address width; must satisfy 2^AW >= H_RES*V_RES
- CW, 3, colour width
- FILL_COLOUR, 0, colour used in mode 0 and in place of keyed pixels in mode 3
- KEY_COLOUR, 3'b100, colour masked in mode 3
- BORDER_COLOUR, 3'b111, border colour; used only with FRAME_BORDER_EN

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-low reset
- start  in  1  request a frame paint; sampled only in IDLE
- mode  in  2  0 fill, 1 ROM A, 2 ROM B, 3 ROM B keyed; latched on accepted start
- rom_addr  out  AW  pixel index y*H_RES+x to both ROMs; registered-address ROMs with 1-cycle latency
- rom_a_q  in  CW  ROM A data
- rom_b_q  in  CW  ROM B data
- busy  out  1  high from the cycle after start is accepted until done
- done  out  1  one-cycle pulse after the last pixel write
- wren  out  1  framebuffer write enable
- x  out  XW  pixel column for the current write
- y  out  YW  pixel row for the current write
- colour  out  CW  pixel colour for the current write

Behaviour:
- Reset: clk and rst are as stated: reset rst, synchronous, active-low; clock clk. While rst=0: state=IDLE, counters=0, latched mode=0, rom_addr=0, busy=0, done=0, wren=0, x=0, y=0, colour=0.
- Reset mid-paint: the frame is abandoned. No further wren, and no done pulse.
- States:
  - IDLE: start=1 → PAINT. Latches mode and clears the x/y counters and address counter.
  - PAINT: one pixel per cycle. rom_addr is the address counter. The x counter wraps from H_RES-1 to 0 and increments y. When the issued pixel is (H_RES-1, V_RES-1) → FLUSH.
  - FLUSH: one cycle to drain the last pipelined pixel → DONE.
  - DONE: done=1 for exactly one cycle → IDLE.
- Pipeline:
  - Pixel issued in PAINT cycle k is written, with wren=1, in cycle k+1.
  - In that cycle x/y are the registered copies of the counters, and colour is derived from the ROM q.
  - First wren occurs 2 cycles after the edge that accepted start.
  - wren is high for exactly H_RES*V_RES consecutive cycles.
  - done asserts the cycle after the last wren.
- Colour selection uses the latched mode:
  - mode 0: FILL_COLOUR
  - mode 1: rom_a_q
  - mode 2: rom_b_q
  - mode 3: rom_b_q, except FILL_COLOUR when rom_b_q==KEY_COLOUR
- busy: 1 in PAINT, FLUSH and DONE.
- start while busy: ignored. No restart, and no re-latch of mode.
- mode changes during a paint: no effect.
- start held continuously: a new frame starts on the cycle after DONE, i.e. back-to-back frames with one IDLE cycle between them.
- Arithmetic: the address counter is AW bits and the x/y counters are XW/YW bits. The counters never exceed H_RES-1 / V_RES-1, and the address never exceeds H_RES*V_RES-1. There is no wrap of rom_addr past the last pixel.

Optional Feature:
- FRAME_BORDER_EN defined: any written pixel with x==0, x==H_RES-1, y==0 or y==V_RES-1 takes BORDER_COLOUR. This overrides all modes, including the key substitution.
- Undefined: no override. The BORDER_COLOUR parameter is unused and there is no extra logic.

Test Plan:
- Fill: rst released, mode=0, start 1 cycle:
  - first wren 2 cycles later at (0,0);
  - exactly 19200 wren cycles, all colour=0;
  - last write at (159,119);
  - done=1 for one cycle immediately after;
  - busy low the following cycle.
- ROM A pass-through: ROM model returns addr[2:0].
  - Write at (159,0) has colour 7.
  - Next write is (0,1) with colour 0.
  - The write for addr 161 is at (1,1) with colour 1.
  - No gaps in wren.
- Keyed mode 3: ROM B returns 3'b100 for even addresses and 3'b011 for odd.
  - Even pixels are written with 0.
  - Odd pixels are written with 3'b011.
- Handshake:
  - start re-pulsed and mode set to 1 at pixel 500 of a mode-0 paint: ignored; the frame stays all 0 and completes normally.
  - start held high: second frame's first wren occurs exactly 3 cycles after the first done.
- Reset mid-paint: rst=0 for 1 cycle at pixel 1000.
  - Next cycle wren=0, busy=0, done never pulses.
  - A subsequent start paints a full 19200-pixel frame.
- FRAME_BORDER_EN, mode 1 with ROM all 3'b010:
  - (0,5), (159,7), (3,0) and (3,119) are written with 3'b111.
  - (1,1) is written with 3'b010.
  - With the macro undefined, all pixels are 3'b010.
